// File: rtl/trivium_pkg.sv
// Shared types, constants and the single-round Trivium update used by the cipher engine.
package trivium_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int KEY_BYTES   = 10;
  localparam int IV_BYTES    = 10;
  localparam int WARM_ROUNDS = 1152;
  localparam int STATE_W     = 288;

  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic               z;
  } round_t;

  // Bit s[i-1] holds Trivium state bit s_i; z is produced before the shift.
  function automatic round_t trivium_round(input logic [STATE_W-1:0] s);
    logic   t1, t2, t3;
    round_t r;
    t1  = s[65] ^ s[92];
    t2  = s[161] ^ s[176];
    t3  = s[242] ^ s[287];
    r.z = t1 ^ t2 ^ t3;
    t1  = t1 ^ (s[90] & s[91]) ^ s[170];
    t2  = t2 ^ (s[174] & s[175]) ^ s[263];
    t3  = t3 ^ (s[285] & s[286]) ^ s[68];
    r.s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return r;
  endfunction

endpackage

// File: rtl/trivium_crypt_fifo_fifo.sv
// Show-ahead FIFO with registered level and almost-full flag; pointers carry a wrap bit.
module trivium_fifo
  import trivium_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] level_nx;
  logic          push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_comb begin
    level_nx = level;
    case ({push_ok, pop_ok})
      2'b10:   level_nx = level + LVL_ONE;
      2'b01:   level_nx = level - LVL_ONE;
      default: level_nx = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      afull  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nx;
      afull <= (level_nx >= AFULL_L);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trivium_crypt_fifo.sv
// Trivium engine: byte-serial key/IV load, unrolled warm-up, XOR of accepted words into a FIFO.
//
// state | meaning
// IDLE  | no key loaded, waiting for first cfg byte
// LOAD  | collecting 20 key/IV bytes
// WARM  | running 1152 initialisation rounds, DATA_W per cycle
// RUN   | encrypting/decrypting accepted words
module trivium_crypt_fifo
  import trivium_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    cfg_data,
  input  logic                          cfg_stb,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_vld,
  output logic                          din_rdy,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          afull,
  output logic [1:0]                    state_o
);

  localparam int WARM_CYC  = WARM_ROUNDS / DATA_W;
  localparam int CW        = $clog2(WARM_ROUNDS);
  localparam int KIV_W     = (KEY_BYTES + IV_BYTES) * 8;
  localparam int LAST_BYTE = KEY_BYTES + IV_BYTES - 1;

  state_t             state, state_nx;
  logic [4:0]         byte_cnt;
  logic [CW-1:0]      warm_cnt;
  logic [KIV_W-1:0]   kiv;
  logic [KIV_W-1:0]   kiv_full;
  logic [STATE_W-1:0] cstate, init_state, adv_state;
  logic [DATA_W-1:0]  z;
  logic               last_byte, accept, fifo_empty, fifo_full;
  round_t             r;

  assign last_byte = (state == LOAD) && cfg_stb && (byte_cnt == 5'(LAST_BYTE));
  assign din_rdy   = (state == RUN) && !cfg_stb && !fifo_full;
  assign accept    = din_vld && din_rdy;
  assign dout_vld  = !fifo_empty;
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cfg_stb) state_nx = LOAD;
      LOAD: if (last_byte) state_nx = WARM;
      WARM: begin
        if (cfg_stb)             state_nx = LOAD;
        else if (warm_cnt == '0) state_nx = RUN;
      end
      RUN:  if (cfg_stb) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // The 20th byte is taken straight from the port so the cipher state loads on that edge.
  always_comb begin
    kiv_full             = {cfg_data, kiv[KIV_W-9:0]};
    init_state           = '0;
    init_state[79:0]     = kiv_full[79:0];
    init_state[172:93]   = kiv_full[159:80];
    init_state[287:285]  = 3'b111;
  end

  always_comb begin
    adv_state = cstate;
    z         = '0;
    r         = '0;
    for (int j = 0; j < DATA_W; j++) begin
      r         = trivium_round(adv_state);
      z[j]      = r.z;
      adv_state = r.s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      kiv      <= '0;
      warm_cnt <= '0;
      cstate   <= '0;
    end else begin
      if (cfg_stb) begin
        if (state == LOAD) begin
          kiv[{byte_cnt, 3'b000} +: 8] <= cfg_data;
          byte_cnt <= last_byte ? 5'd0 : byte_cnt + 5'd1;
        end else begin
          kiv[7:0] <= cfg_data;
          byte_cnt <= 5'd1;
        end
      end
      if (last_byte) begin
        cstate   <= init_state;
        warm_cnt <= CW'(WARM_CYC - 1);
      end else begin
        if ((state == WARM && !cfg_stb) || accept) cstate <= adv_state;
        if (state == WARM && warm_cnt != '0) warm_cnt <= warm_cnt - CW'(1);
      end
    end
  end

  trivium_fifo #(
    .W         (DATA_W),
    .DEPTH     (FIFO_DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (din ^ z),
    .pop   (dout_rdy),
    .rdata (dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level),
    .afull (afull)
  );

endmodule

// File: tb/tb_trivium_crypt_fifo.sv
// Self-checking bench for trivium_crypt_fifo against a bit-level Trivium model using 1-based state indices.
module tb_trivium_crypt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    cfg_data = '0;
  logic          cfg_stb = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy = 1'b0;
  logic [LW-1:0] level;
  logic          afull;
  logic [1:0]    state_o;

  int errors = 0;
  int checks = 0;
  bit ms [1:288];

  trivium_crypt_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_stb(cfg_stb),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .level(level), .afull(afull), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic model_round(output bit zb);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    zb = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = t2;
  endtask

  task automatic model_init(input logic [79:0] k, input logic [79:0] iv);
    bit dummy;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = iv[i-1];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    for (int i = 0; i < 1152; i++) model_round(dummy);
  endtask

  task automatic model_byte(output logic [7:0] zw);
    bit b;
    for (int j = 0; j < 8; j++) begin
      model_round(b);
      zw[j] = b;
    end
  endtask

  task automatic load_key(input logic [79:0] k, input logic [79:0] iv, input int first);
    for (int i = first; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (state_o !== 2'd1) begin
          errors++;
          $display("FAIL load_state byte=%0d got=%0d want=1", i, state_o);
        end
      end
      cfg_stb  = 1'b1;
      cfg_data = (i < 10) ? k[8*i +: 8] : iv[8*(i-10) +: 8];
    end
    @(negedge clk);
    cfg_stb = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd2) begin
      errors++;
      $display("FAIL warm_entry got=%0d want=2", state_o);
    end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (state_o !== 2'd3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state_o !== 2'd3) begin
      errors++;
      $display("FAIL run_timeout state=%0d", state_o);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    int n;
    din = w;
    din_vld = 1'b1;
    #1;
    n = 0;
    while (!din_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!din_rdy) begin
      errors++;
      $display("FAIL push_timeout din_rdy=%0b want=1", din_rdy);
    end
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic pop_word(output logic [7:0] w);
    int n;
    #1;
    n = 0;
    while (!dout_vld && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!dout_vld) begin
      errors++;
      $display("FAIL pop_timeout dout_vld=%0b want=1", dout_vld);
    end
    w = dout;
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({state_o, din_rdy, dout, dout_vld, level, afull} !== '0) begin
      errors++;
      $display("FAIL reset_outputs state=%0d rdy=%0b dout=%h vld=%0b level=%0d afull=%0b want all 0",
               state_o, din_rdy, dout, dout_vld, level, afull);
    end
    din = 8'hFF;
    din_vld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (din_rdy !== 1'b0) begin
        errors++;
        $display("FAIL idle_din_rdy cycle=%0d got=%0b want=0", i, din_rdy);
      end
    end
    din_vld = 1'b0;
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL idle_level got=%0d want=0", level);
    end
  endtask

  task automatic test_keystream();
    logic [7:0] exp [16];
    logic [7:0] got;
    int n;
    model_init('0, '0);
    load_key('0, '0, 0);
    wait_run(n);
    checks++;
    if (n != 1152 / DW) begin
      errors++;
      $display("FAIL warm_cycles got=%0d want=%0d", n, 1152 / DW);
    end
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL run_din_rdy got=%0b want=1", din_rdy);
    end
    for (int i = 0; i < 16; i++) begin
      model_byte(exp[i]);
      push_word(8'h00);
    end
    checks++;
    if (level !== LW'(16)) begin
      errors++;
      $display("FAIL ks_level got=%0d want=16", level);
    end
    for (int i = 0; i < 16; i++) begin
      pop_word(got);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL keystream idx=%0d got=%h want=%h", i, got, exp[i]);
      end
    end
    checks++;
    if (dout_vld !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL drained_empty vld=%0b dout=%h want 0/00", dout_vld, dout);
    end
  endtask

  task automatic test_round_trip();
    logic [79:0] k, iv;
    logic [7:0]  pt [32];
    logic [7:0]  ct [32];
    logic [7:0]  exp [16];
    logic [7:0]  zw, got;
    int n;
    k  = 80'h0123456789abcdef0123;
    iv = {10{8'hA5}};
    model_init(k, iv);
    load_key(k, iv, 0);
    wait_run(n);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin
        pt[16*b + i] = 8'($urandom_range(0, 255));
        model_byte(zw);
        exp[i] = pt[16*b + i] ^ zw;
        push_word(pt[16*b + i]);
      end
      for (int i = 0; i < 16; i++) begin
        pop_word(got);
        ct[16*b + i] = got;
        checks++;
        if (got !== exp[i]) begin
          errors++;
          $display("FAIL encrypt idx=%0d got=%h want=%h", 16*b + i, got, exp[i]);
        end
      end
    end
    load_key(k, iv, 0);
    wait_run(n);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) push_word(ct[16*b + i]);
      for (int i = 0; i < 16; i++) begin
        pop_word(got);
        checks++;
        if (got !== pt[16*b + i]) begin
          errors++;
          $display("FAIL decrypt idx=%0d got=%h want=%h", 16*b + i, got, pt[16*b + i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] rk, riv;
    logic [7:0]  w [17];
    logic [7:0]  exp [17];
    logic [7:0]  zw, got;
    int n;
    rk  = {$urandom(), $urandom(), $urandom()};
    riv = {$urandom(), $urandom(), $urandom()};
    model_init(rk[79:0], riv[79:0]);
    load_key(rk[79:0], riv[79:0], 0);
    wait_run(n);
    for (int i = 0; i < 17; i++) w[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) begin
      model_byte(zw);
      exp[i] = w[i] ^ zw;
      push_word(w[i]);
      checks++;
      if (level !== LW'(i + 1) || afull !== (i + 1 >= AFL)) begin
        errors++;
        $display("FAIL fill_level push=%0d level=%0d afull=%0b want %0d/%0b",
                 i, level, afull, i + 1, (i + 1 >= AFL));
      end
    end
    din = w[16];
    din_vld = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b0 || level !== LW'(16)) begin
      errors++;
      $display("FAIL full_block rdy=%0b level=%0d want 0/16", din_rdy, level);
    end
    @(negedge clk);
    dout_rdy = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b0 || dout !== exp[0]) begin
      errors++;
      $display("FAIL full_pop rdy=%0b dout=%h want 0/%h", din_rdy, dout, exp[0]);
    end
    @(negedge clk);
    dout_rdy = 1'b0;
    #1;
    checks++;
    if (level !== LW'(15) || din_rdy !== 1'b1 || afull !== 1'b1) begin
      errors++;
      $display("FAIL after_pop level=%0d rdy=%0b afull=%0b want 15/1/1", level, din_rdy, afull);
    end
    model_byte(zw);
    exp[16] = w[16] ^ zw;
    @(negedge clk);
    din_vld = 1'b0;
    checks++;
    if (level !== LW'(16)) begin
      errors++;
      $display("FAIL refill_level got=%0d want=16", level);
    end
    for (int i = 1; i < 17; i++) begin
      pop_word(got);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL bp_order idx=%0d got=%h want=%h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_rekey();
    logic [95:0] rk, riv;
    logic [7:0]  exp [8];
    logic [7:0]  w, zw, got;
    int n;
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom_range(0, 255));
      model_byte(zw);
      exp[i] = w ^ zw;
      push_word(w);
    end
    rk  = {$urandom(), $urandom(), $urandom()};
    riv = {$urandom(), $urandom(), $urandom()};
    cfg_stb  = 1'b1;
    cfg_data = rk[7:0];
    din      = 8'h5A;
    din_vld  = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rekey_rdy got=%0b want=0", din_rdy);
    end
    load_key(rk[79:0], riv[79:0], 1);
    din_vld = 1'b0;
    checks++;
    if (level !== LW'(5)) begin
      errors++;
      $display("FAIL rekey_level got=%0d want=5", level);
    end
    for (int i = 0; i < 5; i++) begin
      pop_word(got);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL rekey_drain idx=%0d got=%h want=%h", i, got, exp[i]);
      end
    end
    model_init(rk[79:0], riv[79:0]);
    wait_run(n);
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom_range(0, 255));
      model_byte(zw);
      exp[i] = w ^ zw;
      push_word(w);
    end
    for (int i = 0; i < 8; i++) begin
      pop_word(got);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL rekey_stream idx=%0d got=%h want=%h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [95:0] rk, riv;
    logic [7:0]  exp [2];
    logic [7:0]  w, zw, got;
    int n;
    rk  = {$urandom(), $urandom(), $urandom()};
    riv = {$urandom(), $urandom(), $urandom()};
    load_key(rk[79:0], riv[79:0], 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({state_o, din_rdy, dout, dout_vld, level, afull} !== '0) begin
      errors++;
      $display("FAIL warm_reset state=%0d rdy=%0b dout=%h vld=%0b level=%0d want all 0",
               state_o, din_rdy, dout, dout_vld, level);
    end
    @(negedge clk);
    rst = 1'b1;
    load_key(rk[79:0], riv[79:0], 0);
    wait_run(n);
    for (int i = 0; i < 3; i++) push_word(8'($urandom_range(0, 255)));
    checks++;
    if (level !== LW'(3) || dout_vld !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset level=%0d vld=%0b want 3/1", level, dout_vld);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({state_o, din_rdy, dout, dout_vld, level, afull} !== '0) begin
      errors++;
      $display("FAIL run_reset state=%0d rdy=%0b dout=%h vld=%0b level=%0d want all 0",
               state_o, din_rdy, dout, dout_vld, level);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle state=%0d vld=%0b want 0/0", state_o, dout_vld);
    end
    model_init(rk[79:0], riv[79:0]);
    load_key(rk[79:0], riv[79:0], 0);
    wait_run(n);
    checks++;
    if (n != 1152 / DW) begin
      errors++;
      $display("FAIL resume_warm got=%0d want=%0d", n, 1152 / DW);
    end
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom_range(0, 255));
      model_byte(zw);
      exp[i] = w ^ zw;
      push_word(w);
    end
    for (int i = 0; i < 2; i++) begin
      pop_word(got);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL resume_stream idx=%0d got=%h want=%h", i, got, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_keystream();
    test_round_trip();
    test_backpressure();
    test_rekey();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trivium_crypt_fifo.md
# trivium_crypt_fifo

Parametrised Trivium stream-cipher engine with an integrated output FIFO. It loads an 80-bit key and an 80-bit IV byte-serially, runs the 1152-round warm-up, then XORs each accepted input word with DATA_W keystream bits and queues the result. It replaces the fixed 8-bit cipher-plus-FIFO pairing at the top level. It adds configurable width and depth, valid/ready handshakes on both sides, an almost-full flag and re-keying mid-stream.

## Interface
- DATA_W, 8: word width and keystream bits produced per accepted beat; legal values 1, 2, 4, 8, 16, 32, 64.
- FIFO_DEPTH, 16: FIFO entries; power of 2, at least 2.
- AFULL_LVL, FIFO_DEPTH-2: level at or above which `afull` is asserted.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_data  in  8  key/IV byte.
- cfg_stb  in  1  one-cycle strobe qualifying `cfg_data`.
- din  in  DATA_W  plaintext or ciphertext word.
- din_vld  in  1  input word valid.
- din_rdy  out  1  engine accepts `din` this cycle.
- dout  out  DATA_W  FIFO head word; 0 when empty.
- dout_vld  out  1  FIFO not empty.
- dout_rdy  in  1  consumer pops the head this cycle.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- afull  out  1  level >= AFULL_LVL.
- state_o  out  2  current FSM state encoding.

## Operation
- FSM states: IDLE=0, LOAD=1, WARM=2, RUN=3.
- IDLE: a cfg_stb moves to LOAD and captures that byte as byte 0.
- LOAD: 20 bytes total. Bytes 0–9 are the key; byte i bit b goes to K[8i+b]. Bytes 10–19 are the IV, same mapping.
- On the 20th byte the state is loaded as follows: s1..s80=K0..K79, s81..s93=0, s94..s173=IV0..IV79, s174..s285=0, s286..s288=1. The FSM then goes to WARM.
- WARM: the core advances DATA_W rounds per cycle (unrolled) for 1152/DATA_W cycles. A down-counter tracks this. At zero the FSM goes to RUN.
- RUN: din_rdy = !full. On din_vld && din_rdy:
  - dout word = din XOR z, where z[0] is the first keystream bit generated.
  - The word is written to the FIFO.
  - The core advances DATA_W rounds.
- The keystream never advances without an accepted beat.
- Re-key: a cfg_stb in WARM or RUN aborts, enters LOAD, and takes that byte as byte 0. FIFO contents are preserved. din_rdy drops in the same cycle.
- din_rdy is 0 in IDLE, LOAD and WARM. din beats outside RUN are ignored.
- cfg_stb in LOAD always counts as the next byte.
- FIFO is show-ahead:
  - dout = mem[rd_ptr] when !empty, else 0.
  - Pop on dout_vld && dout_rdy.
  - dout_rdy while empty is ignored.
- Pointers are one bit wider than the address, giving wrap-around full/empty detection.
- Simultaneous push and pop leaves level unchanged.
- din_rdy has no combinational path from dout_rdy. When the FIFO is full, a same-cycle pop does not enable a push.

## Timing
- Reset values: state IDLE, din_rdy 0, dout 0, dout_vld 0, level 0, afull 0 (AFULL_LVL>0), state_o 0. Cipher state, counters and pointers are all 0.
- Reset mid-operation returns to IDLE immediately and discards FIFO contents.
- 20th cfg_stb at cycle N: state_o=2 at N+1.
- RUN entered at N+1+1152/DATA_W; din_rdy high that cycle if the FIFO is not full.
- Beat accepted at cycle M: dout_vld and the updated level visible at M+1.
- Pop at cycle P: the next word (or 0) appears at P+1.
- afull and level are registered and update with the pointers.

## Structure
- Package `trivium_pkg`:
  - `state_t` enum (IDLE/LOAD/WARM/RUN).
  - Constants `KEY_BYTES=10`, `IV_BYTES=10`, `WARM_ROUNDS=1152`, `STATE_W=288`.
  - A function performing one Trivium round on a 288-bit state and returning the new state and output bit.
- Sub-module `trivium_fifo`, parametrised by width and depth: provides push/pop, level and flags.
- Top: FSM, byte counter, warm counter, cipher state register, unrolled round loop.

## Test plan
- Reset then idle: all outputs 0. din_vld=1 with din=0xFF for 50 cycles gives no din_rdy and level stays 0.
- Load key=0, IV=0 (20 zero bytes), DATA_W=8:
  - state_o goes 1 then 2, then 3 exactly 144 cycles after the 20th byte.
  - Feeding 16 words of 0x00 yields dout bytes equal to the bit-level reference model keystream.
- Round trip: encrypt 32 random words under key=0x0123…, IV=0xA5…. Re-key with the same key and IV, then feed back the ciphertext. Outputs must equal the original words.
- Backpressure, FIFO_DEPTH=16, dout_rdy=0:
  - After 16 accepted beats din_rdy=0, level=16, afull=1 from level 14.
  - A pop when full followed by a push keeps ordering intact.
- Re-key mid-stream: cfg_stb while 5 words are queued.
  - din_rdy drops the same cycle and the 5 words drain unchanged.
  - The new keystream matches the model for the new key.
- Async reset asserted during WARM and during RUN with a non-empty FIFO: outputs go to reset values without a clock edge and the FSM resumes from IDLE.
